// File: rtl/axi_memory_slave_wr_engine.sv
// AXI4 memory-slave write engine: captures AW, stores W beats into an
// internal word memory and returns a single B response per transaction.
// Only one write transaction is in flight at a time.
// Build option: AXI_MEM_WR_STRB_EN -- when defined, only the bytes whose
// wstrb bit is set are written. Otherwise every in-range beat writes the
// full word.
//
// state  | meaning
// S_IDLE | awready high, waiting for a write address
// S_DATA | wready high, accepting write beats
// S_RESP | bvalid high, holding the response until bready
module axi_memory_slave_wr_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF;
  localparam int MW     = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic                  fixed_q;
  logic                  wrap_q;
  logic [7:0]            beat_cnt;
  logic                  slverr_q;
  logic                  decerr_q;

  logic                  aw_hs, w_hs, b_hs;
  logic                  cnt_last, final_beat;
  logic [IDX_W-1:0]      word_idx;
  logic [MW-1:0]         mem_idx;
  logic                  in_range;
  logic                  aw_slverr, wrap_len_ok;
  logic [ADDR_WIDTH-1:0] size_bytes, wrap_mask, addr_inc, addr_nxt;
  logic [1:0]            resp_nxt;
  logic                  awready_nxt, wready_nxt, bvalid_nxt;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  assign cnt_last   = (beat_cnt == len_q);
  assign final_beat = w_hs & (wlast | cnt_last);

  assign word_idx = addr_q[ADDR_WIDTH-1:OFF];
  assign mem_idx  = word_idx[MW-1:0];
  assign in_range = ({1'b0, word_idx} < (IDX_W+1)'(MEM_DEPTH));

  // WRAP with an illegal length is flagged and then walks like INCR.
  assign wrap_len_ok = (awlen == 8'd1) | (awlen == 8'd3) | (awlen == 8'd7) | (awlen == 8'd15);
  assign aw_slverr   = (awsize > 3'(OFF)) | (awburst == 2'b11) |
                       ((awburst == 2'b10) & ~wrap_len_ok);

  assign size_bytes = ADDR_WIDTH'(1) << size_q;
  assign wrap_mask  = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
  assign addr_inc   = addr_q + size_bytes;
  assign addr_nxt   = fixed_q ? addr_q :
                      wrap_q  ? ((addr_q & ~wrap_mask) | (addr_inc & wrap_mask)) :
                                addr_inc;

  // The final beat's own errors must land in the response it completes.
  always_comb begin
    resp_nxt = 2'b00;
    if (decerr_q | ~in_range)
      resp_nxt = 2'b11;
    else if (slverr_q | (wlast ^ cnt_last))
      resp_nxt = 2'b10;
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (aw_hs)      state_nxt = S_DATA;
      S_DATA:  if (final_beat) state_nxt = S_RESP;
      S_RESP:  if (b_hs)       state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered, so decode them from the next state.
  always_comb begin
    awready_nxt = (state_nxt == S_IDLE);
    wready_nxt  = (state_nxt == S_DATA);
    bvalid_nxt  = (state_nxt == S_RESP);
  end

  // Handshake output registers; all low while in reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      awready <= awready_nxt;
      wready  <= wready_nxt;
      bvalid  <= bvalid_nxt;
    end
  end

  // Transaction context, beat counting, sticky error flags and B fields.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bid      <= '0;
      bresp    <= 2'b00;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      fixed_q  <= 1'b0;
      wrap_q   <= 1'b0;
      beat_cnt <= '0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        bid      <= awid;
        addr_q   <= awaddr;
        len_q    <= awlen;
        size_q   <= awsize;
        fixed_q  <= (awburst == 2'b00);
        wrap_q   <= (awburst == 2'b10) & wrap_len_ok;
        beat_cnt <= '0;
        slverr_q <= aw_slverr;
        decerr_q <= 1'b0;
      end
      if (w_hs) begin
        addr_q   <= addr_nxt;
        beat_cnt <= beat_cnt + 8'd1;
        if (!in_range)         decerr_q <= 1'b1;
        if (wlast ^ cnt_last)  slverr_q <= 1'b1;
      end
      if (final_beat)
        bresp <= resp_nxt;
    end
  end

`ifdef AXI_MEM_WR_STRB_EN
  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (aresetn && w_hs && in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i])
          mem[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^wstrb;

  // Full-word memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (aresetn && w_hs && in_range)
      mem[mem_idx] <= wdata;
  end
`endif

  // Backdoor read port; a write on the same edge is seen one cycle later.
  always_ff @(posedge aclk) begin
    if (!aresetn) dbg_rdata <= '0;
    else          dbg_rdata <= mem[dbg_addr];
  end

endmodule

// File: tb/tb_axi_memory_slave_wr_engine.sv
// Directed bench for axi_memory_slave_wr_engine. Expected B responses are
// queued when a transaction is issued; a negedge monitor pops and compares
// them on every B handshake and checks B stays stable while stalled.
module tb_axi_memory_slave_wr_engine;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  axi_memory_slave_wr_engine #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(256)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  bexp_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_b_exp  = 0;
  int          n_b_seen = 0;
  logic [31:0] beat_data [16];

`ifdef AXI_MEM_WR_STRB_EN
  localparam logic [31:0] STRB_EXP = 32'hFF34_FF78;
`else
  localparam logic [31:0] STRB_EXP = 32'h1234_5678;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: B handshake scoreboard plus stability while bready is low.
  logic       hold_pending = 1'b0;
  logic [3:0] hold_bid;
  logic [1:0] hold_bresp;
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && bvalid === 1'b1) begin
      if (hold_pending) begin
        chk("b_stable_bid", 64'(bid), 64'(hold_bid));
        chk("b_stable_bresp", 64'(bresp), 64'(hold_bresp));
      end
      if (bready) begin
        hold_pending = 1'b0;
        n_b_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected: got bid=0x%0h bresp=%0b, expected no response", bid, bresp);
        end else begin
          bexp_t e;
          e = exp_q.pop_front();
          chk("b_bid", 64'(bid), 64'(e.id));
          chk("b_bresp", 64'(bresp), 64'(e.resp));
        end
      end else begin
        hold_pending = 1'b1;
        hold_bid     = bid;
        hold_bresp   = bresp;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] bt);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (awready) begin
        tick();
        awvalid = 1'b0;
        return;
      end
      tick();
    end
    awvalid = 1'b0;
    chk("aw_timeout", 64'(awready), 64'd1);
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (wready) begin
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
        return;
      end
      tick();
    end
    wvalid = 1'b0;
    chk("w_timeout", 64'(wready), 64'd1);
  endtask

  task automatic burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input int nbeats,
                       input int last_idx, input logic [3:0] strb, input logic [1:0] resp);
    bexp_t e;
    e.id = id;
    e.resp = resp;
    exp_q.push_back(e);
    n_b_exp++;
    aw_send(id, addr, len, size, bt);
    for (int i = 0; i < nbeats; i++)
      w_send(beat_data[i], strb, (i == last_idx));
  endtask

  task automatic wait_b();
    for (int i = 0; i < 100; i++) begin
      if (n_b_seen >= n_b_exp) break;
      tick();
    end
    chk("b_count", 64'(n_b_seen), 64'(n_b_exp));
  endtask

  task automatic check_mem(input string name, input logic [7:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    tick();
    tick();
    chk(name, 64'(dbg_rdata), 64'(exp));
  endtask

  task automatic check_reset_outputs();
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1; dbg_addr = '0;

    // Reset state, then awready rises on the first cycle after release.
    repeat (3) tick();
    check_reset_outputs();
    aresetn = 1'b1;
    tick();
    chk("idle_awready", 64'(awready), 64'd1);
    chk("idle_wready", 64'(wready), 64'd0);

    // Single INCR beat with W presented alongside AW: minimum latency path.
    begin
      bexp_t e;
      e.id = 4'h3;
      e.resp = 2'b00;
      exp_q.push_back(e);
      n_b_exp++;
    end
    awid = 4'h3; awaddr = 16'h0010; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    chk("w_before_aw_stall", 64'(wready), 64'd0);
    tick();
    awvalid = 1'b0;
    chk("lat_awready_low", 64'(awready), 64'd0);
    chk("lat_wready_high", 64'(wready), 64'd1);
    chk("lat_bvalid_low", 64'(bvalid), 64'd0);
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("lat_wready_drop", 64'(wready), 64'd0);
    chk("lat_bvalid_t2", 64'(bvalid), 64'd1);
    tick();
    chk("post_b_bvalid", 64'(bvalid), 64'd0);
    chk("post_b_awready", 64'(awready), 64'd1);
    wait_b();
    check_mem("single_w4", 8'd4, 32'hDEAD_BEEF);

    // INCR 4 beats with B stalled for 5 cycles.
    for (int i = 0; i < 4; i++) beat_data[i] = 32'(i + 1);
    bready = 1'b0;
    burst(4'h5, 16'h0000, 8'd3, 3'd2, 2'b01, 4, 3, 4'hF, 2'b00);
    for (int i = 0; i < 10; i++) begin
      if (bvalid) break;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid", 64'(bvalid), 64'd1);
      tick();
    end
    bready = 1'b1;
    wait_b();
    for (int i = 0; i < 4; i++) check_mem("incr4_word", 8'(i), 32'(i + 1));

    // WRAP 4 beats from 0x08: words 2,3,0,1.
    beat_data[0] = 32'hAAAA_AAAA; beat_data[1] = 32'hBBBB_BBBB;
    beat_data[2] = 32'hCCCC_CCCC; beat_data[3] = 32'hDDDD_DDDD;
    burst(4'h6, 16'h0008, 8'd3, 3'd2, 2'b10, 4, 3, 4'hF, 2'b00);
    wait_b();
    check_mem("wrap_w2", 8'd2, 32'hAAAA_AAAA);
    check_mem("wrap_w3", 8'd3, 32'hBBBB_BBBB);
    check_mem("wrap_w0", 8'd0, 32'hCCCC_CCCC);
    check_mem("wrap_w1", 8'd1, 32'hDDDD_DDDD);

    // WRAP with illegal length 3 beats -> SLVERR.
    beat_data[0] = 32'h1; beat_data[1] = 32'h2; beat_data[2] = 32'h3;
    burst(4'h7, 16'h0040, 8'd2, 3'd2, 2'b10, 3, 2, 4'hF, 2'b10);
    wait_b();

    // Out-of-range address -> DECERR, no memory word touched.
    beat_data[0] = 32'h0BAD_0BAD;
    burst(4'h8, 16'h0400, 8'd0, 3'd2, 2'b01, 1, 0, 4'hF, 2'b11);
    wait_b();
    check_mem("decerr_w0", 8'd0, 32'hCCCC_CCCC);
    check_mem("decerr_w4", 8'd4, 32'hDEAD_BEEF);

    // Oversized beat -> SLVERR.
    beat_data[0] = 32'h5555_0000;
    burst(4'hC, 16'h0050, 8'd0, 3'd3, 2'b01, 1, 0, 4'hF, 2'b10);
    wait_b();

    // Early wlast on beat 2 of 4 -> SLVERR, 2 beats written.
    beat_data[0] = 32'hE000_0000; beat_data[1] = 32'hE000_0001;
    burst(4'h9, 16'h0000, 8'd3, 3'd2, 2'b01, 2, 1, 4'hF, 2'b10);
    wait_b();
    check_mem("early_w0", 8'd0, 32'hE000_0000);
    check_mem("early_w1", 8'd1, 32'hE000_0001);
    check_mem("early_w2", 8'd2, 32'hAAAA_AAAA);

    // Reserved burst type -> SLVERR, addresses advance as INCR.
    beat_data[0] = 32'h1111_1111; beat_data[1] = 32'h2222_2222;
    burst(4'hD, 16'h0030, 8'd1, 3'd2, 2'b11, 2, 1, 4'hF, 2'b10);
    wait_b();
    check_mem("rsvd_w12", 8'd12, 32'h1111_1111);
    check_mem("rsvd_w13", 8'd13, 32'h2222_2222);

    // FIXED burst: every beat lands on word 14, last one wins.
    beat_data[0] = 32'h3; beat_data[1] = 32'h4; beat_data[2] = 32'h5;
    burst(4'hE, 16'h0038, 8'd2, 3'd2, 2'b00, 3, 2, 4'hF, 2'b00);
    wait_b();
    check_mem("fixed_w14", 8'd14, 32'h5);

    // Byte strobes on word 5.
    beat_data[0] = 32'hFFFF_FFFF;
    burst(4'h1, 16'h0014, 8'd0, 3'd2, 2'b01, 1, 0, 4'hF, 2'b00);
    wait_b();
    beat_data[0] = 32'h1234_5678;
    burst(4'h2, 16'h0014, 8'd0, 3'd2, 2'b01, 1, 0, 4'h5, 2'b00);
    wait_b();
    check_mem("strb_w5", 8'd5, STRB_EXP);

    // Reset after 3 beats of an 8-beat burst.
    for (int i = 0; i < 8; i++) beat_data[i] = 32'hC0DE_0000 + 32'(i);
    aw_send(4'hB, 16'h0000, 8'd7, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) w_send(beat_data[i], 4'hF, 1'b0);
    aresetn = 1'b0;
    tick();
    check_reset_outputs();
    tick();
    aresetn = 1'b1;
    tick();
    chk("rerst_awready", 64'(awready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rerst_no_bvalid", 64'(bvalid), 64'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) check_mem("rerst_word", 8'(i), 32'hC0DE_0000 + 32'(i));
    check_mem("rerst_w3", 8'd3, 32'hBBBB_BBBB);

    beat_data[0] = 32'h600D_600D;
    burst(4'hA, 16'h0060, 8'd0, 3'd2, 2'b01, 1, 0, 4'hF, 2'b00);
    wait_b();
    check_mem("after_rst_w24", 8'd24, 32'h600D_600D);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
